// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode width/limits and the operation encoding
// selected by the mode register. The ALU block consumes the same enum.
package alu_pkg;

    localparam int MODE_W = 3;
    localparam logic [MODE_W-1:0] MODE_MIN = 3'd0;
    localparam logic [MODE_W-1:0] MODE_MAX = 3'd7;

    typedef enum logic [MODE_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_t;

endpackage

// File: rtl/alu_mode_selector_if.sv
// Button inputs and mode/status outputs of the ALU mode selector.
// The slave side is the selector itself; the master side drives the buttons.
interface alu_mode_selector_if;
    import alu_pkg::*;

    logic              control_up;
    logic              control_down;
    logic [MODE_W-1:0] mode;
    logic              mode_changed;
    logic              up_pressed;
    logic              down_pressed;
    logic              at_max;
    logic              at_min;

    modport master (
        output control_up, control_down,
        input  mode, mode_changed, up_pressed, down_pressed, at_max, at_min
    );

    modport slave (
        input  control_up, control_down,
        output mode, mode_changed, up_pressed, down_pressed, at_max, at_min
    );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus consecutive-stable-cycle debouncer for one raw
// push button; emits a one-cycle pulse on each accepted press (0->1 only).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pressed
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             stable_reg;
    logic             pressed_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_reg    <= 1'b0;
            sync_reg    <= 1'b0;
            stable_reg  <= 1'b0;
            pressed_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            meta_reg    <= raw;
            sync_reg    <= meta_reg;
            pressed_reg <= 1'b0;
            // The flip happens on the cycle that completes the N-th differing sample.
            if (sync_reg != stable_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    stable_reg  <= sync_reg;
                    pressed_reg <= sync_reg;
                    cnt_reg     <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level   = stable_reg;
    assign pressed = pressed_reg;
endmodule

// File: rtl/alu_mode_selector.sv
// Debounced up/down buttons step a saturating 3-bit ALU mode register;
// simultaneous presses cancel and held buttons never auto-repeat.
module alu_mode_selector
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_mode_selector_if.slave  bus
);
    // Index 0 is the up button, index 1 the down button.
    logic [1:0] raw_bus;
    logic [1:0] level_unused;
    logic [1:0] pressed_bus;

    logic [MODE_W-1:0] mode_reg;
    logic              mode_changed_reg;

    assign raw_bus = {bus.control_down, bus.control_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debouncer (
                .clk    (clk),
                .rst    (rst),
                .raw    (raw_bus[gi]),
                .level  (level_unused[gi]),
                .pressed(pressed_bus[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_reg         <= MODE_MIN;
            mode_changed_reg <= 1'b0;
        end else begin
            mode_changed_reg <= 1'b0;
            if (pressed_bus[0] && !pressed_bus[1] && mode_reg != MODE_MAX) begin
                mode_reg         <= mode_reg + MODE_W'(1);
                mode_changed_reg <= 1'b1;
            end else if (pressed_bus[1] && !pressed_bus[0] && mode_reg != MODE_MIN) begin
                mode_reg         <= mode_reg - MODE_W'(1);
                mode_changed_reg <= 1'b1;
            end
        end
    end

    assign bus.mode         = mode_reg;
    assign bus.mode_changed = mode_changed_reg;
    assign bus.up_pressed   = pressed_bus[0];
    assign bus.down_pressed = pressed_bus[1];
    assign bus.at_max       = (mode_reg == MODE_MAX);
    assign bus.at_min       = (mode_reg == MODE_MIN);
endmodule

// File: tb/tb_alu_mode_selector.sv
// Directed bench for alu_mode_selector (N=4): expected per-cycle outputs are
// queued when a step is driven and compared one cycle at a time.
module tb_alu_mode_selector;
    localparam int N = 4;

    typedef struct {
        logic [2:0] mode;
        logic       chg;
        logic       up;
        logic       dn;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [2:0] model_mode;
    exp_t sb_q[$];

    alu_mode_selector_if bus ();

    alu_mode_selector #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] m, input logic c, input logic u, input logic d);
        exp_t e;
        e.mode = m; e.chg = c; e.up = u; e.dn = d;
        sb_q.push_back(e);
    endtask

    // Advance one edge, sample at the falling edge, compare against the queue head.
    task automatic step_pop(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, ".mode"},   bus.mode,                 e.mode);
            chk({tag, ".chg"},    {2'b0, bus.mode_changed}, {2'b0, e.chg});
            chk({tag, ".up"},     {2'b0, bus.up_pressed},   {2'b0, e.up});
            chk({tag, ".dn"},     {2'b0, bus.down_pressed}, {2'b0, e.dn});
            chk({tag, ".at_max"}, {2'b0, bus.at_max},       {2'b0, e.mode == 3'd7});
            chk({tag, ".at_min"}, {2'b0, bus.at_min},       {2'b0, e.mode == 3'd0});
        end
        $display("step %s mode=%0d chg=%0b up=%0b dn=%0b", tag, bus.mode,
                 bus.mode_changed, bus.up_pressed, bus.down_pressed);
    endtask

    // Hold the buttons for 'hold' edges (first edge = E0), then idle 'gap' edges.
    task automatic run_press(input string tag, input logic u, input logic d,
                             input int hold, input int gap);
        logic [2:0] nm;
        nm = model_mode;
        if (u && !d && model_mode != 3'd7) nm = model_mode + 3'd1;
        else if (d && !u && model_mode != 3'd0) nm = model_mode - 3'd1;
        for (int k = 0; k < hold + gap; k++)
            push_exp((k >= N + 2) ? nm : model_mode, (k == N + 2) && (nm != model_mode),
                     u && (k == N + 1), d && (k == N + 1));
        model_mode = nm;
        bus.control_up   = u;
        bus.control_down = d;
        for (int k = 0; k < hold + gap; k++) begin
            if (k == hold) begin
                bus.control_up   = 1'b0;
                bus.control_down = 1'b0;
            end
            step_pop(tag);
        end
    endtask

    // Drive an up-button waveform that must never be accepted.
    task automatic run_wave(input string tag, input logic [15:0] upw, input int len);
        for (int k = 0; k < len; k++) push_exp(model_mode, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < len; k++) begin
            bus.control_up = upw[k];
            step_pop(tag);
        end
        bus.control_up = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_mode = 3'd0;
        rst = 1'b0;
        bus.control_up = 1'b0;
        bus.control_down = 1'b0;

        // Reset held with both buttons toggling.
        for (int i = 0; i < 3; i++) begin
            push_exp(3'd0, 1'b0, 1'b0, 1'b0);
            bus.control_up   = ~bus.control_up;
            bus.control_down = ~bus.control_down;
            step_pop("reset");
        end
        rst = 1'b1;
        bus.control_up = 1'b0;
        bus.control_down = 1'b0;
        run_wave("idle", 16'h0000, 8);

        run_press("clean_up", 1'b1, 1'b0, 10, 8);
        run_wave("bounce", 16'h00ED, 16);
        run_press("after_bounce", 1'b1, 1'b0, 6, 8);

        // Single-cycle reset back to 0 before the saturation sweep.
        rst = 1'b0;
        push_exp(3'd0, 1'b0, 1'b0, 1'b0);
        step_pop("reset_pulse");
        rst = 1'b1;
        model_mode = 3'd0;

        for (int i = 0; i < 9; i++) run_press("sat_up", 1'b1, 1'b0, 6, 8);
        for (int i = 0; i < 8; i++) run_press("sat_dn", 1'b0, 1'b1, 6, 8);

        for (int i = 0; i < 3; i++) run_press("to3", 1'b1, 1'b0, 6, 8);
        run_press("both", 1'b1, 1'b1, 8, 8);
        run_press("to2", 1'b0, 1'b1, 6, 8);

        // Down held from mode 2 with a one-cycle reset at E3; press re-accepted at E9.
        for (int k = 0; k < 22; k++)
            push_exp((k < 3) ? model_mode : 3'd0, 1'b0, 1'b0, k == 9);
        bus.control_down = 1'b1;
        for (int k = 0; k < 22; k++) begin
            if (k == 3) rst = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 14) bus.control_down = 1'b0;
            step_pop("rst_mid");
        end
        model_mode = 3'd0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
